// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: N data bits, optional odd/even parity, 1-2 stop bits,
// small input FIFO with valid/ready write side and CTS gating at frame starts.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    localparam int CW          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 cts_i,
    output logic                 data_o,
    output logic                 busy_o,
    output logic [CW-1:0]        fifo_count_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
        $error("PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
        $error("STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fd
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    state_e               state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [IW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 push, pop, load, start_ok, bit_end;
    logic [DATA_BITS-1:0] head;

    assign tx_ready_o   = (count_q != FULL);
    assign fifo_count_o = count_q;
    assign push         = tx_valid_i && tx_ready_o;
    assign head         = mem_q[rd_ptr_q];
    assign start_ok     = (count_q != '0) && cts_i;
    assign bit_end      = (baud_q == BAUD_LAST);

    // Reset discards queued words by clearing pointers; storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shreg_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = (state_q == S_IDLE || bit_end) ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: if (start_ok) begin
                state_d = S_START;
                load    = 1'b1;
            end
            S_START: if (bit_end) begin
                state_d = S_DATA;
                bit_d   = '0;
            end
            S_DATA: if (bit_end) begin
                shreg_d = shreg_q >> 1;
                bit_d   = bit_q + 1'b1;
                stop_d  = 1'b0;
                if (bit_q == BIT_LAST) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (bit_end) begin
                state_d = S_STOP;
                stop_d  = 1'b0;
            end
            S_STOP: if (bit_end) begin
                if (stop_q == STOP_LAST) begin
                    // Chain straight into the next start bit when allowed: no idle gap.
                    if (start_ok) begin
                        state_d = S_START;
                        load    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    stop_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            shreg_d = head;
            par_d   = (PARITY == 1) ? ~^head : ^head;
        end
        pop = load;
    end

    always_comb begin
        case (state_q)
            S_START:  data_o = 1'b0;
            S_DATA:   data_o = shreg_q[0];
            S_PARITY: data_o = par_q;
            default:  data_o = 1'b1;
        endcase
        busy_o = (state_q != S_IDLE);
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed and scoreboard bench for uart_tx_cfg: 8N1, 7E2/7O2 and 9O1 instances
// share one clock and reset; each task drives its own instance and checks inline.
module tb_uart_tx_cfg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 8N1 instance
    logic       v8 = 1'b0, c8 = 1'b0, r8, o8, b8;
    logic [7:0] d8 = '0;
    logic [2:0] n8;
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8)) u8 (
        .clk(clk), .rst(rst), .tx_valid_i(v8), .tx_ready_o(r8), .data_i(d8),
        .cts_i(c8), .data_o(o8), .busy_o(b8), .fifo_count_o(n8));

    // 7E2 and 7O2 instances, driven identically
    logic       v7 = 1'b0, c7 = 1'b0, re, oe, be, ro, oo, bo;
    logic [6:0] d7 = '0;
    logic [2:0] ne, no;
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u7e (
        .clk(clk), .rst(rst), .tx_valid_i(v7), .tx_ready_o(re), .data_i(d7),
        .cts_i(c7), .data_o(oe), .busy_o(be), .fifo_count_o(ne));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u7o (
        .clk(clk), .rst(rst), .tx_valid_i(v7), .tx_ready_o(ro), .data_i(d7),
        .cts_i(c7), .data_o(oo), .busy_o(bo), .fifo_count_o(no));

    // 9O1 instance for the random scoreboard
    logic       v9 = 1'b0, c9 = 1'b0, r9, o9, b9;
    logic [8:0] d9 = '0;
    logic [2:0] n9;
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) u9 (
        .clk(clk), .rst(rst), .tx_valid_i(v9), .tx_ready_o(r9), .data_i(d9),
        .cts_i(c9), .data_o(o9), .busy_o(b9), .fifo_count_o(n9));

    // Reference receiver for u9: detects the start bit, samples mid-bit, checks odd parity and stop.
    logic       rx_en = 1'b0;
    logic [8:0] rx_w;
    logic       rx_p;
    int         rx_err = 0;
    logic [8:0] rx_q[$];
    logic [8:0] exp_q[$];

    always begin
        @(negedge clk);
        if (rx_en && o9 === 1'b0) begin
            repeat (2) @(negedge clk);
            if (o9 !== 1'b0) rx_err++;
            for (int i = 0; i < 9; i++) begin
                repeat (4) @(negedge clk);
                rx_w[i] = o9;
            end
            repeat (4) @(negedge clk);
            rx_p = o9;
            if ((^rx_w ^ rx_p) !== 1'b1) rx_err++;
            repeat (4) @(negedge clk);
            if (o9 !== 1'b1) rx_err++;
            rx_q.push_back(rx_w);
        end
    end

    task automatic test_reset;
        n_checks++;
        if (o8 !== 1'b1) begin n_fail++; $display("FAIL reset_data_o got %b want 1", o8); end
        n_checks++;
        if (b8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy_o got %b want 0", b8); end
        n_checks++;
        if (r8 !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready_o got %b want 1", r8); end
        n_checks++;
        if (n8 !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_count_o got %0d want 0", n8); end
    endtask

    task automatic test_basic;
        logic [9:0] fr;
        int bad;
        fr  = {1'b1, 8'h55, 1'b0};
        bad = 0;
        c8  = 1'b1;
        @(negedge clk); v8 = 1'b1; d8 = 8'h55;
        @(negedge clk); v8 = 1'b0;
        n_checks++;
        if (o8 !== 1'b1 || b8 !== 1'b0 || n8 !== 3'd1) begin
            n_fail++;
            $display("FAIL basic_pre_start got data_o=%b busy_o=%b count=%0d want 1/0/1", o8, b8, n8);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n_checks++;
            if (o8 !== fr[k/4] || b8 !== 1'b1) begin
                n_fail++;
                if (bad++ < 4) $display("FAIL basic_line k=%0d got data_o=%b busy_o=%b want %b/1", k, o8, b8, fr[k/4]);
            end
        end
        @(negedge clk);
        n_checks++;
        if (o8 !== 1'b1 || b8 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end got data_o=%b busy_o=%b want 1/0", o8, b8);
        end
    endtask

    task automatic test_parity;
        logic [10:0] fe, fo;
        int bad;
        fe  = {2'b11, 1'b0, 7'h41, 1'b0};
        fo  = {2'b11, 1'b1, 7'h41, 1'b0};
        bad = 0;
        c7  = 1'b1;
        @(negedge clk); v7 = 1'b1; d7 = 7'h41;
        @(negedge clk); v7 = 1'b0;
        for (int k = 0; k < 44; k++) begin
            @(negedge clk);
            n_checks++;
            if (oe !== fe[k/4] || be !== 1'b1) begin
                n_fail++;
                if (bad++ < 4) $display("FAIL parity_even k=%0d got data_o=%b busy_o=%b want %b/1", k, oe, be, fe[k/4]);
            end
            n_checks++;
            if (oo !== fo[k/4] || bo !== 1'b1) begin
                n_fail++;
                if (bad++ < 4) $display("FAIL parity_odd k=%0d got data_o=%b busy_o=%b want %b/1", k, oo, bo, fo[k/4]);
            end
        end
        @(negedge clk);
        n_checks++;
        if (be !== 1'b0 || bo !== 1'b0 || oe !== 1'b1 || oo !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_end got busy=%b/%b line=%b/%b want 0/0 1/1", be, bo, oe, oo);
        end
    endtask

    task automatic test_fifo_full;
        logic [9:0] fr;
        int bad;
        bad = 0;
        c8  = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 6; i++) begin
            v8 = 1'b1; d8 = 8'(i);
            @(negedge clk);
        end
        v8 = 1'b0;
        n_checks++;
        if (n8 !== 3'd4 || r8 !== 1'b0) begin
            n_fail++;
            $display("FAIL full_count got count=%0d ready=%b want 4/0", n8, r8);
        end
        n_checks++;
        if (b8 !== 1'b0 || o8 !== 1'b1) begin
            n_fail++;
            $display("FAIL full_cts_hold got busy=%b line=%b want 0/1", b8, o8);
        end
        c8 = 1'b1;
        for (int k = 0; k < 160; k++) begin
            @(negedge clk);
            fr = {1'b1, 8'(k/40 + 1), 1'b0};
            n_checks++;
            if (o8 !== fr[(k%40)/4] || b8 !== 1'b1) begin
                n_fail++;
                if (bad++ < 4) $display("FAIL full_stream k=%0d got data_o=%b busy_o=%b want %b/1", k, o8, b8, fr[(k%40)/4]);
            end
        end
        @(negedge clk);
        n_checks++;
        if (b8 !== 1'b0 || n8 !== 3'd0) begin
            n_fail++;
            $display("FAIL full_drain got busy=%b count=%0d want 0/0", b8, n8);
        end
    endtask

    task automatic test_flow;
        logic [9:0] fa, fb;
        int bad;
        fa  = {1'b1, 8'hA5, 1'b0};
        fb  = {1'b1, 8'h3C, 1'b0};
        bad = 0;
        c8  = 1'b1;
        @(negedge clk); v8 = 1'b1; d8 = 8'hA5;
        @(negedge clk); d8 = 8'h3C;
        @(negedge clk); v8 = 1'b0;
        n_checks++;
        if (n8 !== 3'd1) begin n_fail++; $display("FAIL flow_queued got count=%0d want 1", n8); end
        for (int k = 0; k < 40; k++) begin
            if (k != 0) @(negedge clk);
            n_checks++;
            if (o8 !== fa[k/4] || b8 !== 1'b1) begin
                n_fail++;
                if (bad++ < 4) $display("FAIL flow_frame_a k=%0d got data_o=%b busy_o=%b want %b/1", k, o8, b8, fa[k/4]);
            end
            if (k == 10) c8 = 1'b0;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_checks++;
            if (o8 !== 1'b1 || b8 !== 1'b0 || n8 !== 3'd1) begin
                n_fail++;
                if (bad++ < 4) $display("FAIL flow_hold k=%0d got data_o=%b busy_o=%b count=%0d want 1/0/1", k, o8, b8, n8);
            end
        end
        c8 = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n_checks++;
            if (o8 !== fb[k/4] || b8 !== 1'b1) begin
                n_fail++;
                if (bad++ < 4) $display("FAIL flow_frame_b k=%0d got data_o=%b busy_o=%b want %b/1", k, o8, b8, fb[k/4]);
            end
        end
        @(negedge clk);
        n_checks++;
        if (b8 !== 1'b0 || n8 !== 3'd0) begin
            n_fail++;
            $display("FAIL flow_end got busy=%b count=%0d want 0/0", b8, n8);
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        bad = 0;
        c8  = 1'b1;
        @(negedge clk); v8 = 1'b1; d8 = 8'h11;
        @(negedge clk); d8 = 8'h22;
        @(negedge clk); d8 = 8'h33;
        @(negedge clk); d8 = 8'h44;
        @(negedge clk); v8 = 1'b0;
        n_checks++;
        if (n8 !== 3'd3) begin n_fail++; $display("FAIL rstmid_queued got count=%0d want 3", n8); end
        repeat (8) @(negedge clk);
        // 10 cycles into the 0x11 frame: data bit 1, line low
        n_checks++;
        if (b8 !== 1'b1 || o8 !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_in_data got busy=%b line=%b want 1/0", b8, o8);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (o8 !== 1'b1 || b8 !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async got data_o=%b busy_o=%b want 1/0", o8, b8);
        end
        @(negedge clk); rst = 1'b0;
        n_checks++;
        if (n8 !== 3'd0 || r8 !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_flush got count=%0d ready=%b want 0/1", n8, r8);
        end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            n_checks++;
            if (o8 !== 1'b1 || b8 !== 1'b0 || n8 !== 3'd0) begin
                n_fail++;
                if (bad++ < 4) $display("FAIL rstmid_idle k=%0d got data_o=%b busy_o=%b count=%0d want 1/0/0", k, o8, b8, n8);
            end
        end
    endtask

    task automatic test_scoreboard;
        int sent, cyc, bad;
        sent  = 0;
        cyc   = 0;
        bad   = 0;
        c9    = 1'b1;
        rx_en = 1'b1;
        while (sent < 200 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if ($urandom_range(0, 19) == 0) c9 = ~c9;
            v9 = 1'($urandom_range(0, 1));
            d9 = 9'($urandom);
            if (v9 && r9) begin
                exp_q.push_back(d9);
                sent++;
            end
        end
        @(negedge clk);
        v9 = 1'b0;
        c9 = 1'b1;
        n_checks++;
        if (sent != 200) begin n_fail++; $display("FAIL sb_write_timeout got %0d writes want 200", sent); end
        cyc = 0;
        while ((rx_q.size() < exp_q.size() || b9 !== 1'b0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (rx_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL sb_count got %0d words want %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++;
            if (rx_q[i] !== exp_q[i]) begin
                n_fail++;
                if (bad++ < 4) $display("FAIL sb_word i=%0d got %h want %h", i, rx_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (rx_err != 0) begin n_fail++; $display("FAIL sb_framing got %0d errors want 0", rx_err); end
        rx_en = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_parity;
        test_fifo_full;
        test_flow;
        test_reset_mid;
        test_scoreboard;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
